// File: rtl/mult_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_checker
// Brief    : Checks array/wallace/booth multiplier products against golden
//            results over a bounded self-test campaign; keeps saturating stats.
// Revision : 1.0
// ============================================================================
module mult_result_checker #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_tests,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [2*W-1:0]     prod_array,
    input  logic [2*W-1:0]     prod_wallace,
    input  logic [2*W-1:0]     prod_booth,
    output logic               out_valid,
    output logic [2:0]         out_mask,
    output logic [CNT_W-1:0]   total_cnt,
    output logic [CNT_W-1:0]   err_array_cnt,
    output logic [CNT_W-1:0]   err_wallace_cnt,
    output logic [CNT_W-1:0]   err_booth_cnt,
    output logic               first_fail_vld,
    output logic [2*W-1:0]     first_fail_ab,
    output logic [2:0]         first_fail_mask,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_acc_cnt;

    logic               r_s1_v;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [2*W-1:0]     r_pa;
    logic [2*W-1:0]     r_pw;
    logic [2*W-1:0]     r_pb;

    logic               r_out_valid;
    logic [2:0]         r_out_mask;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_err_a;
    logic [CNT_W-1:0]   r_err_w;
    logic [CNT_W-1:0]   r_err_b;
    logic               r_ff_vld;
    logic [2*W-1:0]     r_ff_ab;
    logic [2:0]         r_ff_mask;

    logic               w_accept;
    logic               w_launch;
    logic [2*W-1:0]     w_exp_u;
    logic [2*W-1:0]     w_exp_s;
    logic [2:0]         w_mask;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + c_one : v;
    endfunction

    assign w_accept = in_valid && (r_state == S_RUN);
    assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Operands are extended to product width before multiplying so the full
    // 2W-bit result is kept in both the unsigned and the signed reference.
    assign w_exp_u = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
    assign w_exp_s = $signed({{W{r_a[W-1]}}, r_a}) * $signed({{W{r_b[W-1]}}, r_b});

    assign w_mask = {r_pb != w_exp_s, r_pw != w_exp_u, r_pa != w_exp_u};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_target  <= '0;
            r_acc_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_target  <= n_tests;
                        r_acc_cnt <= '0;
                        r_state   <= (n_tests == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + c_one;
                        if (r_acc_cnt == r_target - c_one) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_s1_v && !r_out_valid) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_pa        <= '0;
            r_pw        <= '0;
            r_pb        <= '0;
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_total     <= '0;
            r_err_a     <= '0;
            r_err_w     <= '0;
            r_err_b     <= '0;
            r_ff_vld    <= 1'b0;
            r_ff_ab     <= '0;
            r_ff_mask   <= '0;
        end else begin
            r_s1_v      <= w_accept;
            r_out_valid <= r_s1_v;
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_pa <= prod_array;
                r_pw <= prod_wallace;
                r_pb <= prod_booth;
            end
            // A launch only happens with an empty pipeline, so it never races
            // a statistics update.
            if (w_launch) begin
                r_out_mask <= '0;
                r_total    <= '0;
                r_err_a    <= '0;
                r_err_w    <= '0;
                r_err_b    <= '0;
                r_ff_vld   <= 1'b0;
                r_ff_ab    <= '0;
                r_ff_mask  <= '0;
            end else if (r_s1_v) begin
                r_out_mask <= w_mask;
                r_total    <= sat_inc(r_total, 1'b1);
                r_err_a    <= sat_inc(r_err_a, w_mask[0]);
                r_err_w    <= sat_inc(r_err_w, w_mask[1]);
                r_err_b    <= sat_inc(r_err_b, w_mask[2]);
                if (!r_ff_vld && (w_mask != 3'b000)) begin
                    r_ff_vld  <= 1'b1;
                    r_ff_ab   <= {r_a, r_b};
                    r_ff_mask <= w_mask;
                end
            end
        end
    end

    assign in_ready        = (r_state == S_RUN);
    assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign out_valid       = r_out_valid;
    assign out_mask        = r_out_mask;
    assign total_cnt       = r_total;
    assign err_array_cnt   = r_err_a;
    assign err_wallace_cnt = r_err_w;
    assign err_booth_cnt   = r_err_b;
    assign first_fail_vld  = r_ff_vld;
    assign first_fail_ab   = r_ff_ab;
    assign first_fail_mask = r_ff_mask;

endmodule
`default_nettype wire

// File: tb/tb_mult_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_result_checker
// Brief    : Self-checking bench for mult_result_checker (table + random).
// Revision : 1.0
// ============================================================================
module tb_mult_result_checker;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   n_tests = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       a = '0;
    logic [W-1:0]       b = '0;
    logic [2*W-1:0]     prod_array = '0;
    logic [2*W-1:0]     prod_wallace = '0;
    logic [2*W-1:0]     prod_booth = '0;
    logic               out_valid;
    logic [2:0]         out_mask;
    logic [CNT_W-1:0]   total_cnt;
    logic [CNT_W-1:0]   err_array_cnt;
    logic [CNT_W-1:0]   err_wallace_cnt;
    logic [CNT_W-1:0]   err_booth_cnt;
    logic               first_fail_vld;
    logic [2*W-1:0]     first_fail_ab;
    logic [2:0]         first_fail_mask;
    logic               busy;
    logic               done;

    mult_result_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_tests(n_tests),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .prod_array(prod_array), .prod_wallace(prod_wallace), .prod_booth(prod_booth),
        .out_valid(out_valid), .out_mask(out_mask), .total_cnt(total_cnt),
        .err_array_cnt(err_array_cnt), .err_wallace_cnt(err_wallace_cnt),
        .err_booth_cnt(err_booth_cnt), .first_fail_vld(first_fail_vld),
        .first_fail_ab(first_fail_ab), .first_fail_mask(first_fail_mask),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a, b;
        logic [15:0] pa, pw, pb;
        logic [2:0]  mask;
    } vec_t;
    vec_t vt[4];

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: campaign phase 0 idle, 1 accepting, 2 draining, 3 finished.
    int          m_phase, m_target, m_acc, m_total, m_ea, m_ew, m_eb;
    bit          m_p1v, m_ov, m_ffv;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_pa, m_pw, m_pb, m_ffab;
    logic [2:0]  m_mask, m_ffmask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [2:0] ref_mask(input logic [7:0] x, input logic [7:0] y,
                                            input logic [15:0] pa, input logic [15:0] pw,
                                            input logic [15:0] pb);
        int u, s;
        u = int'(x) * int'(y);
        s = int'($signed(x)) * int'($signed(y));
        ref_mask[0] = (int'(pa) != u);
        ref_mask[1] = (int'(pw) != u);
        ref_mask[2] = (int'($signed(pb)) != s);
    endfunction

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_target = 0; m_acc = 0; m_total = 0;
        m_ea = 0; m_ew = 0; m_eb = 0;
        m_p1v = 0; m_ov = 0; m_ffv = 0;
        m_a = '0; m_b = '0; m_pa = '0; m_pw = '0; m_pb = '0;
        m_ffab = '0; m_mask = '0; m_ffmask = '0;
    endtask

    task automatic model_step();
        bit acc, old_p1v, old_ov;
        logic [2:0] mk;
        acc = in_valid && (m_phase == 1);
        old_p1v = m_p1v;
        old_ov = m_ov;
        m_ov = m_p1v;
        if (m_p1v) begin
            mk = ref_mask(m_a, m_b, m_pa, m_pw, m_pb);
            m_mask = mk;
            m_total = sat(m_total);
            if (mk[0]) m_ea = sat(m_ea);
            if (mk[1]) m_ew = sat(m_ew);
            if (mk[2]) m_eb = sat(m_eb);
            if (!m_ffv && mk != 0) begin
                m_ffv = 1; m_ffab = {m_a, m_b}; m_ffmask = mk;
            end
        end
        m_p1v = acc;
        if (acc) begin
            m_a = a; m_b = b; m_pa = prod_array; m_pw = prod_wallace; m_pb = prod_booth;
        end
        if (start && (m_phase == 0 || m_phase == 3)) begin
            m_total = 0; m_ea = 0; m_ew = 0; m_eb = 0; m_mask = 0;
            m_ffv = 0; m_ffab = 0; m_ffmask = 0;
            m_target = int'(n_tests); m_acc = 0;
            m_phase = (n_tests == 0) ? 3 : 1;
        end else if (m_phase == 1 && acc) begin
            m_acc++;
            if (m_acc == m_target) m_phase = 2;
        end else if (m_phase == 2 && !old_p1v && !old_ov) begin
            m_phase = 3;
        end
    endtask

    task automatic check_all();
        chk("in_ready",   32'(in_ready),        32'(m_phase == 1));
        chk("busy",       32'(busy),            32'(m_phase == 1 || m_phase == 2));
        chk("done",       32'(done),            32'(m_phase == 3));
        chk("out_valid",  32'(out_valid),       32'(m_ov));
        chk("out_mask",   32'(out_mask),        32'(m_mask));
        chk("total_cnt",  32'(total_cnt),       32'(m_total));
        chk("err_array",  32'(err_array_cnt),   32'(m_ea));
        chk("err_wallace",32'(err_wallace_cnt), 32'(m_ew));
        chk("err_booth",  32'(err_booth_cnt),   32'(m_eb));
        chk("ff_vld",     32'(first_fail_vld),  32'(m_ffv));
        chk("ff_ab",      32'(first_fail_ab),   32'(m_ffab));
        chk("ff_mask",    32'(first_fail_mask), 32'(m_ffmask));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic drive_sample(input int err_pct);
        logic [7:0]  x, y;
        logic [15:0] u, s;
        x = 8'($urandom);
        y = 8'($urandom);
        u = 16'(int'(x) * int'(y));
        s = 16'(int'($signed(x)) * int'($signed(y)));
        a = x; b = y;
        prod_array   = (int'($urandom_range(99)) < err_pct) ? u ^ 16'(1 << $urandom_range(15)) : u;
        prod_wallace = (int'($urandom_range(99)) < err_pct) ? u ^ 16'(1 << $urandom_range(15)) : u;
        prod_booth   = (int'($urandom_range(99)) < err_pct) ? s ^ 16'(1 << $urandom_range(15)) : s;
    endtask

    task automatic run_table(input int first, input int cnt);
        int k;
        k = 0;
        n_tests = CNT_W'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < cnt + 20; i++) begin
            if (i < cnt) begin
                in_valid = 1'b1;
                a = vt[first+i].a; b = vt[first+i].b;
                prod_array = vt[first+i].pa; prod_wallace = vt[first+i].pw;
                prod_booth = vt[first+i].pb;
            end else begin
                in_valid = 1'b0;
            end
            if (i >= cnt && m_phase == 3) break;
            tick();
            if (out_valid) begin
                if (k < cnt) chk("tbl_mask", 32'(out_mask), 32'(vt[first+k].mask));
                k++;
            end
        end
        in_valid = 1'b0;
        chk("tbl_pulses", k, cnt);
        chk("tbl_done", 32'(done), 32'd1);
    endtask

    task automatic run_campaign(input int n, input int err_pct, input int gap_pct,
                                input bit noise, input int rst_at);
        n_tests = CNT_W'(n); start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (m_phase == 3) break;
            if (t == rst_at) begin
                do_reset();
                return;
            end
            in_valid = (int'($urandom_range(99)) >= gap_pct);
            drive_sample(err_pct);
            start = noise && ($urandom_range(9) == 0);
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
        chk("campaign_done", 32'(done), 32'd1);
    endtask

    initial begin
        int acc3;
        vt[0] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 3'b000};
        vt[1] = '{8'hFF, 8'hFF, 16'hFE01, 16'hFE01, 16'h0001, 3'b000};
        vt[2] = '{8'hAA, 8'h55, 16'h3872, 16'h3872, 16'hE372, 3'b000};
        vt[3] = '{8'h80, 8'h02, 16'h0100, 16'h0000, 16'hFF00, 3'b010};

        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean samples, then a single wallace failure
        run_table(0, 3);
        chk("t1_total", 32'(total_cnt), 32'd3);
        run_table(3, 1);
        chk("t2_err_w", 32'(err_wallace_cnt), 32'd1);
        chk("t2_ff_ab", 32'(first_fail_ab), 32'h8002);
        chk("t2_ff_mask", 32'(first_fail_mask), 32'b010);

        // in_valid held high longer than the campaign
        acc3 = 0;
        n_tests = CNT_W'(2); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            drive_sample(0);
            if (in_ready) acc3++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_accepts", acc3, 2);
        chk("t3_total", 32'(total_cnt), 32'd2);

        // Zero-length campaign
        n_tests = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) tick();

        // Full-scale counters, no wrap, then reset mid-campaign
        run_campaign(15, 0, 20, 1'b0, -1);
        chk("t4_total", 32'(total_cnt), 32'd15);
        run_campaign(15, 100, 20, 1'b0, -1);
        chk("t4_err_a", 32'(err_array_cnt), 32'd15);
        chk("t4_err_w", 32'(err_wallace_cnt), 32'd15);
        chk("t4_err_b", 32'(err_booth_cnt), 32'd15);
        run_campaign(15, 100, 0, 1'b0, 6);
        chk("t4_rst_total", 32'(total_cnt), 32'd0);

        // Reset with samples in flight in both stages
        n_tests = CNT_W'(5); start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; drive_sample(100); tick();
        drive_sample(100); tick();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_pulse", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;

        for (int r = 0; r < 10; r++) begin
            run_campaign(int'($urandom_range(1, 15)), 30, 30, 1'b1, -1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
